// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode constants and index helpers for the N-to-1 selector
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Next channel index after idx, wrapping back to 0 past the last of n channels
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_nx1.sv
// rtl/rr_arbiter_nx1.sv - combinational round-robin pick starting at ptr
module rr_arbiter_nx1
    import mux_pkg::*;
#(
    parameter int N     = 3,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             enable,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Walk ptr, ptr+1, ..., wrapping once around, and take the first requester
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
            idx = SEL_W'(wrap_inc(int'(idx), N));
        end
        grant_valid = found && enable;
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - registered N-to-1 selector with select and round-robin modes
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 3,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               rr_en,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   grant,
    output logic               sel_err
);

    localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_valid;
    logic [SEL_W-1:0] cand;
    logic             cand_ok;
    logic             cand_in_valid;
    logic [WIDTH-1:0] cand_data;
    logic             load_en;
    logic             sel_ok;
    logic             transfer;

    rr_arbiter_nx1 #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .enable      (rr_en == MODE_RR),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = ({1'b0, sel} < N_W);

    // Choose the candidate channel for this cycle and offer it in_ready
    always_comb begin
        cand          = (rr_en == MODE_RR) ? arb_grant : sel;
        cand_ok       = (rr_en == MODE_RR) ? arb_valid : sel_ok;
        cand_in_valid = 1'b0;
        cand_data     = '0;
        in_ready      = '0;
        for (int i = 0; i < N; i++) begin
            if (cand == SEL_W'(i)) begin
                cand_in_valid = in_valid[i];
                cand_data     = in_data[i*WIDTH +: WIDTH];
                in_ready[i]   = reset_n && load_en && cand_ok;
            end
        end
        transfer = reset_n && load_en && cand_ok && cand_in_valid;
    end

    // Output register, round-robin pointer and sticky select error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            grant     <= '0;
            ptr       <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (transfer) begin
                out_data  <= cand_data;
                grant     <= cand;
                out_valid <= 1'b1;
                if (rr_en == MODE_RR) begin
                    ptr <= SEL_W'(wrap_inc(int'(cand), N));
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if ((rr_en == MODE_SEL) && !sel_ok) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - directed table-driven bench for mux_nx1_rr
module tb_mux_nx1_rr;

    localparam int WIDTH = 8;
    localparam int N     = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [1:0]        sel;
    logic              rr_en;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant;
    logic              sel_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rr;
        logic [1:0] sel;
        logic [2:0] vld;
        logic       ordy;
        logic [2:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_g;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    mux_nx1_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_en     (rr_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rr, input logic [1:0] s, input logic [2:0] v, input logic o,
                       input logic [2:0] er, input logic eov, input logic [7:0] eod,
                       input logic [1:0] eg, input logic eerr);
        vec_t t;
        t.rr = rr; t.sel = s; t.vld = v; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_g = eg; t.exp_err = eerr;
        vecs.push_back(t);
    endtask

    task automatic check_regs(input string tag, input logic eov, input logic [7:0] eod,
                              input logic [1:0] eg, input logic eerr);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, " out_data"},  32'(out_data),  32'(eod));
        chk({tag, " grant"},     32'(grant),     32'(eg));
        chk({tag, " sel_err"},   32'(sel_err),   32'(eerr));
    endtask

    initial begin
        //   rr   sel   vld     ordy  exp_rdy exp_ov exp_od  g     err
        add(1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b0);
        add(1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd3, 3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b0);
        add(1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b0);
        add(1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd0, 3'b110, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b1, 2'd0, 3'b110, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd0, 3'b110, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b1, 2'd0, 3'b110, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 2'd2, 1'b0);
        add(1'b1, 2'd0, 3'b000, 1'b0, 3'b000, 1'b0, 8'h33, 2'd2, 1'b0);
        add(1'b0, 2'd0, 3'b001, 1'b0, 3'b001, 1'b1, 8'h11, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++)
            add(1'b0, 2'd1, 3'b111, 1'b0, 3'b000, 1'b1, 8'h11, 2'd0, 1'b0);
        add(1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1, 1'b0);
        add(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'h22, 2'd1, 1'b1);
        add(1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b1);
        add(1'b1, 2'd3, 3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0, 1'b1);

        in_data   = {8'h33, 8'h22, 8'h11};
        in_valid  = 3'b111;
        sel       = 2'd0;
        rr_en     = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;

        // Reset state, with valid inputs pending
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        check_regs("reset", 1'b0, 8'h00, 2'd0, 1'b0);

        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 3'b000;
        @(posedge clk);

        // Table vectors: in_ready before the edge, registers after it
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rr_en     = vecs[i].rr;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].vld;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_od,
                       vecs[i].exp_g, vecs[i].exp_err);
        end

        // Reset while holding a word with ch0 pending: word dropped, ch0 not taken
        @(negedge clk);
        reset_n   = 1'b0;
        rr_en     = 1'b0;
        sel       = 2'd0;
        in_valid  = 3'b001;
        in_data   = {8'h33, 8'h22, 8'h5a};
        out_ready = 1'b0;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_regs("midreset", 1'b0, 8'h00, 2'd0, 1'b0);

        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = 3'b000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset idle out_valid", 32'(out_valid), 32'd0);

        // Pointer was cleared by reset: round robin starts at ch0 again
        @(negedge clk);
        rr_en    = 1'b1;
        in_valid = 3'b111;
        #1;
        chk("post reset rr in_ready", 32'(in_ready), 32'b001);
        @(posedge clk);
        #1;
        check_regs("post reset rr", 1'b1, 8'h5a, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
